// File: rtl/norm_sequencer.sv
// Post-add normalizer: classifies the ALU sum, then left-shifts one bit per
// cycle until the significand is normalized or the exponent clamps to denormal.
module norm_sequencer #(
  parameter int SIG_W = 24,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_sig,
  input  logic             in_carry,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_sig,
  output logic [EXP_W-1:0] out_shift,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [EXP_W-1:0]        EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0]        EXP_MAX  = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic signed [EXP_W-1:0] SH_ZERO  = '0;
  localparam logic signed [EXP_W-1:0] SH_PLUS1 = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] SH_MIN1  = '1;

  state_t                  state;
  logic [EXP_W-1:0]        exp_q;
  logic [SIG_W-1:0]        sig_q;
  logic signed [EXP_W-1:0] shift_q;
  logic                    ovf_q;
  logic                    valid_q;
  logic                    ready_q;
  logic                    busy_q;
  logic [EXP_W-1:0]        eff_exp;

  // Exponent the result would carry if the block stopped shifting now.
  assign eff_exp = exp_q + $unsigned(shift_q);

  assign out_sig   = sig_q;
  assign out_shift = $unsigned(shift_q);
  assign out_ovf   = ovf_q;
  assign out_valid = valid_q;
  assign in_ready  = ready_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      exp_q   <= '0;
      sig_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            exp_q   <= in_exp;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= DONE;
            valid_q <= 1'b1;
            if (in_carry) begin
              sig_q   <= {1'b1, in_sig[SIG_W-1:1]};
              shift_q <= SH_PLUS1;
              ovf_q   <= (in_exp == EXP_MAX);
            end else if (in_sig == '0) begin
              sig_q   <= '0;
              shift_q <= (in_exp == EXP_ONE) ? SH_MIN1 : SH_ZERO;
            end else if (in_exp == '0) begin
              sig_q   <= in_sig;
              shift_q <= SH_ZERO;
            end else if (in_exp == EXP_ONE && !in_sig[SIG_W-1]) begin
              sig_q   <= in_sig;
              shift_q <= SH_MIN1;
            end else if (in_sig[SIG_W-1]) begin
              sig_q   <= in_sig;
              shift_q <= SH_ZERO;
            end else begin
              sig_q   <= in_sig;
              shift_q <= SH_ZERO;
              state   <= SHIFT;
              valid_q <= 1'b0;
            end
          end
        end

        SHIFT: begin
          shift_q <= shift_q - SH_PLUS1;
          if (eff_exp == EXP_ONE) begin
            // Exponent floor reached: stop shifting, result goes denormal.
            state   <= DONE;
            valid_q <= 1'b1;
          end else begin
            sig_q <= {sig_q[SIG_W-2:0], 1'b0};
            if (sig_q[SIG_W-2]) begin
              state   <= DONE;
              valid_q <= 1'b1;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_norm_sequencer.sv
// Directed and randomized checks of norm_sequencer against a closed-form
// normalization model (leading-zero count and exponent floor).
module tb_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_sig;
  logic        in_carry;
  logic [7:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_sig;
  logic [7:0]  out_shift;
  logic        out_ovf;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  norm_sequencer #(.SIG_W(24), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_carry(in_carry), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sig(out_sig), .out_shift(out_shift), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Expected result from the normalization rules, in closed form.
  function automatic void model(input logic [23:0] s, input logic c, input logic [7:0] e,
                                output logic [23:0] rs, output logic [7:0] rsh,
                                output logic ro, output int lat);
    int lz;
    lat = 1;
    ro  = 1'b0;
    rs  = s;
    rsh = 8'h00;
    if (c) begin
      rs  = {1'b1, s[23:1]};
      rsh = 8'h01;
      ro  = (e == 8'hFE);
    end else if (s == 24'h0) begin
      rs  = 24'h0;
      rsh = (e == 8'h01) ? 8'hFF : 8'h00;
    end else begin
      lz = 0;
      for (int b = 23; b >= 0; b--) begin
        if (s[b]) break;
        lz++;
      end
      if (e == 8'h00 || lz == 0) begin
        rsh = 8'h00;
      end else if (e == 8'h01) begin
        rsh = 8'hFF;
      end else if (int'(e) - 1 >= lz) begin
        rs  = s << lz;
        rsh = 8'(-lz);
        lat = 1 + lz;
      end else begin
        rs  = s << (int'(e) - 1);
        rsh = 8'(-int'(e));
        lat = 1 + int'(e);
      end
    end
  endfunction

  task automatic junk_inputs();
    in_valid = 1'b1;
    in_sig   = 24'($urandom);
    in_carry = 1'($urandom);
    in_exp   = 8'($urandom);
  endtask

  task automatic do_op(input logic [23:0] s, input logic c, input logic [7:0] e,
                       input int hold, input string tag);
    logic [23:0] es;
    logic [7:0]  esh;
    logic        eo;
    int          elat;
    int          cyc;
    model(s, c, e, es, esh, eo, elat);
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sig = s; in_carry = c; in_exp = e;
    @(posedge clk);
    @(negedge clk);
    junk_inputs();
    cyc = 1;
    while (!out_valid && cyc < 64) begin
      @(negedge clk);
      junk_inputs();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(elat));
    chk({tag, "_sig"}, 32'(out_sig), 32'(es));
    chk({tag, "_shift"}, 32'(out_shift), 32'(esh));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      junk_inputs();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_sig"}, 32'(out_sig), 32'(es));
      chk({tag, "_hold_shift"}, 32'(out_shift), 32'(esh));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [23:0] rs;
    logic        rc;
    logic [7:0]  re;
    int          pick;
    rst = 1'b1; in_valid = 1'b0; in_sig = '0; in_carry = 1'b0; in_exp = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_sig", 32'(out_sig), 32'd0);
    chk("rst_out_shift", 32'(out_shift), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(24'h400000, 1'b0, 8'h80, 0, "one_shift");
    do_op(24'h000001, 1'b0, 8'h80, 1, "full_shift");
    do_op(24'h000002, 1'b1, 8'hFE, 0, "carry_ovf");
    do_op(24'h123456, 1'b1, 8'h10, 0, "carry_no_ovf");
    do_op(24'h100000, 1'b0, 8'h03, 0, "clamp");
    do_op(24'h000000, 1'b0, 8'h01, 5, "zero_e1");
    do_op(24'h000000, 1'b0, 8'h40, 0, "zero");
    do_op(24'h000123, 1'b0, 8'h00, 0, "denorm_pass");
    do_op(24'h400000, 1'b0, 8'h01, 0, "to_denorm");
    do_op(24'h800000, 1'b0, 8'h01, 0, "norm_e1");
    do_op(24'h200000, 1'b0, 8'h02, 0, "clamp_e2");

    // Abort an operation mid-shift with an asynchronous reset.
    @(negedge clk);
    in_valid = 1'b1; in_sig = 24'h000001; in_carry = 1'b0; in_exp = 8'h80;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_shift_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out_shift", 32'(out_shift), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(24'h800000, 1'b0, 8'h10, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 7);
      rc = (pick == 0);
      rs = (pick == 1) ? 24'h0 : 24'(24'($urandom) >> $urandom_range(0, 23));
      case ($urandom_range(0, 5))
        0: re = 8'h00;
        1: re = 8'h01;
        2: re = 8'($urandom_range(2, 6));
        3: re = 8'hFE;
        default: re = 8'($urandom);
      endcase
      do_op(rs, rc, re, $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
